// File: rtl/cpu64_pipeline_ctrl.sv
// Pipeline hazard/stall controller for a five-stage 64-bit core.
// Arbitrates traps, memory waits, multicycle mul/div, redirects and load-use hazards.
module cpu64_pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int MD_TIMEOUT   = 63
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_use_i,
  input  logic       redirect_i,
  input  logic       trap_i,
  input  logic       imem_wait_i,
  input  logic       dmem_wait_i,
  input  logic       md_start_i,
  input  logic       md_done_i,
  output logic [4:0] stall_o,
  output logic [4:0] bubble_o,
  output logic [4:0] squash_o,
  output logic [1:0] pc_sel_o,
  output logic       md_abort_o,
  output logic       md_timeout_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {RUN, MD_BUSY, MEM_WAIT, TRAP_DRAIN} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [5:0] MD_LIMIT   = 6'(MD_TIMEOUT);
  localparam logic [1:0] PC_SEQ     = 2'd0;
  localparam logic [1:0] PC_REDIR   = 2'd1;
  localparam logic [1:0] PC_TRAP    = 2'd2;

  state_t     state, state_next;
  logic [3:0] drain_cnt, drain_next;
  logic [5:0] md_cnt, md_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= RUN;
      drain_cnt <= '0;
      md_cnt    <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
      md_cnt    <= md_next;
    end
  end

  // Trap always wins; md_done only matters while the mul/div unit is busy.
  always_comb begin
    state_next = state;
    drain_next = drain_cnt;
    md_next    = md_cnt;
    case (state)
      RUN: begin
        if (trap_i) begin
          state_next = TRAP_DRAIN;
          drain_next = DRAIN_LOAD;
        end else if (dmem_wait_i) begin
          state_next = MEM_WAIT;
        end else if (md_start_i) begin
          state_next = MD_BUSY;
          md_next    = '0;
        end
      end
      MEM_WAIT: begin
        if (trap_i) begin
          state_next = TRAP_DRAIN;
          drain_next = DRAIN_LOAD;
        end else if (!dmem_wait_i) begin
          state_next = RUN;
        end
      end
      MD_BUSY: begin
        if (trap_i) begin
          state_next = TRAP_DRAIN;
          drain_next = DRAIN_LOAD;
        end else if (md_done_i || md_cnt == MD_LIMIT) begin
          state_next = RUN;
        end else begin
          md_next = md_cnt + 6'd1;
        end
      end
      TRAP_DRAIN: begin
        if (drain_cnt == 4'd0) state_next = RUN;
        else                   drain_next = drain_cnt - 4'd1;
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    stall_o      = '0;
    bubble_o     = '0;
    squash_o     = '0;
    pc_sel_o     = PC_SEQ;
    md_abort_o   = 1'b0;
    md_timeout_o = 1'b0;
    if (!rst_ni) begin
      squash_o = 5'b11111;
    end else begin
      case (state)
        RUN: begin
          if (trap_i) begin
            squash_o = 5'b01111;
            pc_sel_o = PC_TRAP;
          end else if (dmem_wait_i) begin
            stall_o  = 5'b01111;
            bubble_o = 5'b10000;
          end else if (md_start_i) begin
            stall_o  = 5'b00111;
            bubble_o = 5'b01000;
          end else if (redirect_i) begin
            // The squashed IF slot stays invalid while fetch is stalled, so no bubble is needed.
            squash_o = 5'b00011;
            pc_sel_o = PC_REDIR;
            if (imem_wait_i) stall_o = 5'b00001;
          end else if (load_use_i) begin
            stall_o  = 5'b00011;
            bubble_o = 5'b00100;
          end else if (imem_wait_i) begin
            stall_o  = 5'b00001;
            bubble_o = 5'b00010;
          end
        end
        MEM_WAIT: begin
          if (trap_i) begin
            squash_o = 5'b01111;
            pc_sel_o = PC_TRAP;
          end else if (dmem_wait_i) begin
            stall_o  = 5'b01111;
            bubble_o = 5'b10000;
          end
        end
        MD_BUSY: begin
          if (trap_i) begin
            squash_o   = 5'b01111;
            pc_sel_o   = PC_TRAP;
            md_abort_o = 1'b1;
          end else if (!md_done_i) begin
            stall_o  = 5'b00111;
            bubble_o = 5'b01000;
            if (md_cnt == MD_LIMIT) begin
              md_timeout_o = 1'b1;
              md_abort_o   = 1'b1;
            end
          end
        end
        TRAP_DRAIN: begin
          stall_o  = 5'b00001;
          bubble_o = 5'b00010;
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state != RUN);

endmodule

// File: tb/tb_cpu64_pipeline_ctrl.sv
// Directed scoreboard bench for cpu64_pipeline_ctrl with default parameters.
// Expected outputs are queued when inputs are driven and checked on the falling edge.
module tb_cpu64_pipeline_ctrl;

  logic       clk;
  logic       rst_n;
  logic       load_use, redirect, trap, imem_wait, dmem_wait, md_start, md_done;
  logic [4:0] stall, bubble, squash;
  logic [1:0] pc_sel;
  logic       md_abort, md_timeout, busy;

  typedef struct {
    string       tag;
    logic [19:0] value;
  } exp_t;

  exp_t scoreboard[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Input bit order: {trap, dmem_wait, md_start, md_done, redirect, load_use, imem_wait}
  localparam logic [6:0] I_NONE  = 7'b0000000;
  localparam logic [6:0] I_TRAP  = 7'b1000000;
  localparam logic [6:0] I_DMEM  = 7'b0100000;
  localparam logic [6:0] I_START = 7'b0010000;
  localparam logic [6:0] I_DONE  = 7'b0001000;
  localparam logic [6:0] I_REDIR = 7'b0000100;
  localparam logic [6:0] I_LU    = 7'b0000010;
  localparam logic [6:0] I_IMEM  = 7'b0000001;

  cpu64_pipeline_ctrl #(.DRAIN_CYCLES(2), .MD_TIMEOUT(63)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_use_i   (load_use),
    .redirect_i   (redirect),
    .trap_i       (trap),
    .imem_wait_i  (imem_wait),
    .dmem_wait_i  (dmem_wait),
    .md_start_i   (md_start),
    .md_done_i    (md_done),
    .stall_o      (stall),
    .bubble_o     (bubble),
    .squash_o     (squash),
    .pc_sel_o     (pc_sel),
    .md_abort_o   (md_abort),
    .md_timeout_o (md_timeout),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] ev(input logic [4:0] st, input logic [4:0] bu,
                                     input logic [4:0] sq, input logic [1:0] pc,
                                     input logic ab, input logic to, input logic bz);
    return {st, bu, sq, pc, ab, to, bz};
  endfunction

  task automatic applyStimulus(input logic [6:0] ins, input logic [19:0] expv, input string tag);
    exp_t e;
    {trap, dmem_wait, md_start, md_done, redirect, load_use, imem_wait} = ins;
    e.tag   = tag;
    e.value = expv;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [19:0] obs;
    obs = {stall, bubble, squash, pc_sel, md_abort, md_timeout, busy};
    vectors++;
    if (scoreboard.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty observed=%h required=queued expectation", obs);
    end else begin
      e = scoreboard.pop_front();
      assert (obs === e.value) else begin
        miscompares++;
        $error("[TB] FAIL %s observed stall=%b bubble=%b squash=%b pc=%0d abort=%b tmo=%b busy=%b required stall=%b bubble=%b squash=%b pc=%0d abort=%b tmo=%b busy=%b",
               e.tag, obs[19:15], obs[14:10], obs[9:5], obs[4:3], obs[2], obs[1], obs[0],
               e.value[19:15], e.value[14:10], e.value[9:5], e.value[4:3], e.value[2], e.value[1], e.value[0]);
      end
    end
  endtask

  // One cycle: drive just after the rising edge, check on the falling edge.
  task automatic step(input logic [6:0] ins, input logic [19:0] expv, input string tag);
    applyStimulus(ins, expv, tag);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {trap, dmem_wait, md_start, md_done, redirect, load_use, imem_wait} = I_NONE;
    repeat (2) @(posedge clk);
    #1;
    step(I_NONE, ev(5'h00, 5'h00, 5'h1F, 2'd0, 0, 0, 0), "reset_state");
    rst_n = 1'b1;

    step(I_NONE, ev(5'h00, 5'h00, 5'h00, 2'd0, 0, 0, 0), "run_idle");
    step(I_IMEM, ev(5'h01, 5'h02, 5'h00, 2'd0, 0, 0, 0), "imem_wait");
    step(I_LU, ev(5'h03, 5'h04, 5'h00, 2'd0, 0, 0, 0), "load_use");
    step(I_LU | I_IMEM, ev(5'h03, 5'h04, 5'h00, 2'd0, 0, 0, 0), "load_use_imem");
    step(I_REDIR, ev(5'h00, 5'h00, 5'h03, 2'd1, 0, 0, 0), "redirect");
    step(I_REDIR | I_LU | I_IMEM, ev(5'h01, 5'h00, 5'h03, 2'd1, 0, 0, 0), "redir_lu_imem");
    step(I_DONE, ev(5'h00, 5'h00, 5'h00, 2'd0, 0, 0, 0), "done_in_run");

    // Trap with two drain cycles; a redirect during drain must be ignored.
    step(I_TRAP, ev(5'h00, 5'h00, 5'h0F, 2'd2, 0, 0, 0), "trap_run");
    step(I_REDIR, ev(5'h01, 5'h02, 5'h00, 2'd0, 0, 0, 1), "drain_1");
    step(I_NONE, ev(5'h01, 5'h02, 5'h00, 2'd0, 0, 0, 1), "drain_2");
    step(I_NONE, ev(5'h00, 5'h00, 5'h00, 2'd0, 0, 0, 0), "drain_exit");

    // Mul/div completes five cycles after start.
    step(I_START, ev(5'h07, 5'h08, 5'h00, 2'd0, 0, 0, 0), "md_start");
    for (int i = 0; i < 4; i++)
      step(I_NONE, ev(5'h07, 5'h08, 5'h00, 2'd0, 0, 0, 1), "md_busy");
    step(I_DONE, ev(5'h00, 5'h00, 5'h00, 2'd0, 0, 0, 1), "md_done");
    step(I_NONE, ev(5'h00, 5'h00, 5'h00, 2'd0, 0, 0, 0), "md_after_done");

    // Mul/div never finishes: pulse on the 64th busy cycle.
    step(I_START, ev(5'h07, 5'h08, 5'h00, 2'd0, 0, 0, 0), "tmo_start");
    for (int i = 0; i < 63; i++)
      step(I_NONE, ev(5'h07, 5'h08, 5'h00, 2'd0, 0, 0, 1), "tmo_wait");
    step(I_NONE, ev(5'h07, 5'h08, 5'h00, 2'd0, 1, 1, 1), "tmo_pulse");
    step(I_NONE, ev(5'h00, 5'h00, 5'h00, 2'd0, 0, 0, 0), "tmo_after");

    // Trap beats md_done while busy.
    step(I_START, ev(5'h07, 5'h08, 5'h00, 2'd0, 0, 0, 0), "mdtrap_start");
    step(I_NONE, ev(5'h07, 5'h08, 5'h00, 2'd0, 0, 0, 1), "mdtrap_busy");
    step(I_TRAP | I_DONE, ev(5'h00, 5'h00, 5'h0F, 2'd2, 1, 0, 1), "mdtrap_trap");
    step(I_NONE, ev(5'h01, 5'h02, 5'h00, 2'd0, 0, 0, 1), "mdtrap_drain1");
    step(I_NONE, ev(5'h01, 5'h02, 5'h00, 2'd0, 0, 0, 1), "mdtrap_drain2");
    step(I_NONE, ev(5'h00, 5'h00, 5'h00, 2'd0, 0, 0, 0), "mdtrap_run");

    // Data memory wait, held then released.
    step(I_DMEM, ev(5'h0F, 5'h10, 5'h00, 2'd0, 0, 0, 0), "dmem_enter");
    step(I_DMEM, ev(5'h0F, 5'h10, 5'h00, 2'd0, 0, 0, 1), "dmem_hold");
    step(I_NONE, ev(5'h00, 5'h00, 5'h00, 2'd0, 0, 0, 1), "dmem_release");
    step(I_NONE, ev(5'h00, 5'h00, 5'h00, 2'd0, 0, 0, 0), "dmem_run");

    // Trap during a memory wait does not abort the mul/div unit.
    step(I_DMEM, ev(5'h0F, 5'h10, 5'h00, 2'd0, 0, 0, 0), "memtrap_enter");
    step(I_DMEM | I_TRAP, ev(5'h00, 5'h00, 5'h0F, 2'd2, 0, 0, 1), "memtrap_trap");
    step(I_NONE, ev(5'h01, 5'h02, 5'h00, 2'd0, 0, 0, 1), "memtrap_drain1");
    step(I_NONE, ev(5'h01, 5'h02, 5'h00, 2'd0, 0, 0, 1), "memtrap_drain2");
    step(I_NONE, ev(5'h00, 5'h00, 5'h00, 2'd0, 0, 0, 0), "memtrap_run");

    // Asynchronous reset in the middle of a memory wait.
    step(I_DMEM, ev(5'h0F, 5'h10, 5'h00, 2'd0, 0, 0, 0), "rst_enter");
    step(I_DMEM, ev(5'h0F, 5'h10, 5'h00, 2'd0, 0, 0, 1), "rst_memwait");
    rst_n = 1'b0;
    step(I_DMEM, ev(5'h00, 5'h00, 5'h1F, 2'd0, 0, 0, 0), "rst_mid");
    rst_n = 1'b1;
    step(I_NONE, ev(5'h00, 5'h00, 5'h00, 2'd0, 0, 0, 0), "rst_release");
    step(I_IMEM, ev(5'h01, 5'h02, 5'h00, 2'd0, 0, 0, 0), "rst_post_imem");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu64_pipeline_ctrl.md
CPU64_PIPELINE_CTRL -- requirements
Module: cpu64_pipeline_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 2: post-trap drain length in cycles, legal range 1..15.
REQ-002 SHALL have parameter MD_TIMEOUT, default 63: maximum MD_BUSY cycles, legal range 1..63.
REQ-003 SHALL have port clk_i  input  1  single system clock, rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port load_use_i  input  1  ID instruction depends on a load in EX.
REQ-006 SHALL have port redirect_i  input  1  EX resolved a taken or mispredicted branch or jump.
REQ-007 SHALL have port trap_i  input  1  exception raised by the instruction in MEM.
REQ-008 SHALL have port imem_wait_i  input  1  instruction fetch not ready.
REQ-009 SHALL have port dmem_wait_i  input  1  data access in MEM not ready.
REQ-010 SHALL have port md_start_i  input  1  multicycle mul/div issued from EX.
REQ-011 SHALL have port md_done_i  input  1  mul/div result ready.
REQ-012 SHALL have port stall_o  output  5  per-stage stall; bit 0=IF, 1=ID, 2=EX, 3=MEM, 4=WB.
REQ-013 SHALL have port bubble_o  output  5  per-stage bubble; same bit order.
REQ-014 SHALL have port squash_o  output  5  per-stage squash; same bit order.
REQ-015 SHALL have port pc_sel_o  output  2  next-PC source: 0=sequential, 1=redirect, 2=trap vector.
REQ-016 SHALL have port md_abort_o  output  1  one-cycle pulse that cancels the mul/div unit.
REQ-017 SHALL have port md_timeout_o  output  1  one-cycle pulse on mul/div timeout.
REQ-018 SHALL have port busy_o  output  1  high whenever state is not RUN.

Function
REQ-019 SHALL implement FSM states RUN, MD_BUSY, MEM_WAIT, TRAP_DRAIN, plus a 4-bit drain counter and a 6-bit mul/div counter.
REQ-020 SHALL hold state and counters in registers; all outputs SHALL be combinational from state, counters and current inputs, with zero-cycle latency.
REQ-021 SHALL, in RUN, apply one event per cycle in priority order: trap_i, dmem_wait_i, md_start_i, redirect_i, load_use_i, imem_wait_i.
REQ-022 SHALL, on trap_i: squash_o=5'b01111, pc_sel_o=2, load drain counter with DRAIN_CYCLES-1, next state TRAP_DRAIN.
REQ-023 SHALL, in TRAP_DRAIN: stall_o=5'b00001, bubble_o=5'b00010; decrement the counter each cycle; go to RUN in the cycle after the counter reads 0; ignore all other inputs.
REQ-024 SHALL, on dmem_wait_i: stall_o=5'b01111, bubble_o=5'b10000, next state MEM_WAIT.
REQ-025 SHALL keep the REQ-024 outputs in MEM_WAIT while dmem_wait_i=1, and return to RUN in the first cycle with dmem_wait_i=0, driving no stall in that cycle.
REQ-026 SHALL, on md_start_i: stall_o=5'b00111, bubble_o=5'b01000, clear the mul/div counter, next state MD_BUSY.
REQ-027 SHALL keep the REQ-026 outputs in MD_BUSY, incrementing the counter each cycle.
REQ-028 SHALL leave MD_BUSY for RUN when md_done_i=1, releasing the stall in that same cycle.
REQ-029 SHALL, in MD_BUSY, pulse md_timeout_o and md_abort_o and go to RUN when the counter equals MD_TIMEOUT and md_done_i=0.
REQ-030 SHALL, on trap_i in MD_BUSY or MEM_WAIT: apply REQ-022 and pulse md_abort_o if the state was MD_BUSY; trap_i has priority over md_done_i.
REQ-031 SHALL, on redirect_i: squash_o=5'b00011, pc_sel_o=1.
REQ-032 SHALL treat redirect_i together with load_use_i as redirect only, because the dependent ID instruction is squashed.
REQ-033 SHALL, on redirect_i together with imem_wait_i: squash_o=5'b00011 and stall_o=5'b00001 in the same cycle; the stage validity tracker retains the squash while stalled.
REQ-034 SHALL, on load_use_i: stall_o=5'b00011, bubble_o=5'b00100.
REQ-035 SHALL, on imem_wait_i alone: stall_o=5'b00001, bubble_o=5'b00010.
REQ-036 SHALL never assert stall_o and bubble_o on the same bit.
REQ-037 SHALL ignore md_done_i outside MD_BUSY.

Reset
REQ-038 SHALL, while rst_ni=0: state=RUN, both counters 0, stall_o=0, bubble_o=0, squash_o=5'b11111, pc_sel_o=0, md_abort_o=0, md_timeout_o=0, busy_o=0.
REQ-039 SHALL, on reset asserted mid-operation in any state, apply REQ-038 asynchronously, and start in RUN on the first edge after release.

Verification
REQ-040 SHALL test: trap_i for 1 cycle in RUN with DRAIN_CYCLES=2 -> squash_o=01111 and pc_sel_o=2 in that cycle, then exactly 2 cycles of stall_o=00001/bubble_o=00010, then RUN.
REQ-041 SHALL test: md_start_i, then md_done_i 5 cycles later -> stall_o=00111 held for 5 cycles, released in the md_done_i cycle, busy_o=0 on the next cycle.
REQ-042 SHALL test: md_start_i with md_done_i never asserted, MD_TIMEOUT=63 -> md_timeout_o and md_abort_o pulse in the 64th MD_BUSY cycle, then RUN.
REQ-043 SHALL test: redirect_i+load_use_i+imem_wait_i in one cycle -> squash_o=00011, stall_o=00001, bubble_o=00000, pc_sel_o=1.
REQ-044 SHALL test: trap_i on the same cycle as md_done_i in MD_BUSY -> md_abort_o=1, squash_o=01111, next state TRAP_DRAIN.
REQ-045 SHALL test: rst_ni low for 1 cycle during MEM_WAIT -> outputs per REQ-038 immediately, and RUN with no stall after release.
